relu_maxpool2x2: RTL and testbench
==================================

# relu_maxpool2x2

Streaming ReLU plus 2×2/stride-2 max-pool stage that sits directly downstream of the convolution datapath. It consumes the 16-bit convolution results in raster order, one result per `in_valid` beat. For a 28×28 image this is a 26×26 feature map. It emits the pooled feature map, 13×13 by default, in raster order. A single half-width line buffer holds the row-pair partial maxima, so the block never stores a full frame.

## Interface
- `IW`, default 26: input feature-map width in results. Must be ≥ 2.
- `IH`, default 26: input feature-map height in rows. Must be ≥ 2.
- `DW`, default 16: data width of the convolution result, two's-complement signed.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- `in_valid`  input  1  one convolution result is presented this cycle. Gaps are allowed.
- `in_data`  input  DW  signed convolution result.
- `out_valid`  output  1  one pooled result is presented this cycle; single-cycle pulse.
- `out_data`  output  DW  pooled result; always ≥ 0.
- `out_last`  output  1  coincides with `out_valid` of the final pooled result of a frame.
- `frame_done`  output  1  one-cycle pulse after the last input beat of a frame.

## Operation
- Output dimensions are OW = floor(IW/2) and OH = floor(IH/2). The line buffer holds OW entries of DW bits.
- Counters:
  - column `c` runs 0..IW-1 and row `r` runs 0..IH-1.
  - Both advance only on `in_valid`.
  - `c` wraps to 0 at IW-1 and increments `r`.
  - `r` wraps to 0 at IH-1, so the next frame starts immediately.
- ReLU: x' = 0 if `in_data` is negative, otherwise `in_data`. All max comparisons are unsigned on x'.
- Horizontal pair:
  - When c is even and c < 2·OW, register h = x'.
  - When c is odd, m = max(h, x').
  - When c = IW-1 and IW is odd, the beat is consumed and discarded.
- Vertical pair:
  - On an even row r < 2·OH, write m into lb[c>>1].
  - On an odd row, produce max(lb[c>>1], m) as an output.
  - When r = IH-1 and IH is odd, the whole row is consumed and discarded.
- Comparisons that tie select either operand; the value is identical.
- There is no backpressure. The downstream stage accepts every `out_valid` beat.
- Reset values:
  - `out_valid`, `out_last`, `frame_done` = 0; `out_data` = 0.
  - c = 0, r = 0, h = 0.
  - Line-buffer contents are don't-care: every entry is rewritten on an even row before it is read.
- Reset asserted mid-frame aborts the frame with no output. The first beat after release is taken as pixel (0,0).

## Timing
- Latency: `out_valid` rises exactly 1 cycle after the `in_valid` beat at (r odd, c odd) inside the 2·OH × 2·OW region.
- Output rate is at most one beat every 2 input beats.
- `out_last` is asserted with the output produced from (2·OH-1, 2·OW-1).
- `frame_done` pulses 1 cycle after the beat at (IH-1, IW-1), including odd dimensions where that beat yields no output.
  - With even dimensions, `frame_done` coincides with the `out_valid`/`out_last` of the final output.
- Back-to-back frames: a beat at (0,0) in the cycle after (IH-1, IW-1) is accepted normally. The line-buffer write for row 0 does not disturb the final output of the previous frame, which is already registered.
- `in_valid` low: counters, h and the line buffer hold. `out_valid` is 0 in the following cycle.
- `out_data` holds its last value when `out_valid` is 0.

## Test plan
- **Ramp, 4×4.** IW=IH=4, inputs 0..15 on consecutive cycles.
  - Outputs 5, 7, 13, 15.
  - `out_last` on 15; `frame_done` in the same cycle.
- **All negative, default size.** All inputs 0xFFFF (-1).
  - 169 outputs, all 0.
  - `out_last` on output 169; `frame_done` in that cycle.
- **Bubbles.** 4×4 ramp with `in_valid` toggled 1,0,1,0.
  - Same outputs 5, 7, 13, 15.
  - Each `out_valid` 1 cycle after its triggering beat; no output in bubble-following cycles.
- **Odd dimensions.** IW=IH=5, inputs 0..24.
  - Outputs 6, 8, 16, 18; `out_last` on 18.
  - `frame_done` 1 cycle after input 24, which is 6 beats after the 18 trigger.
- **Mixed sign.** 2×2 inputs -300, 7, -1, 0x7FFF.
  - Single output 0x7FFF with `out_last` = 1.
- **Reset mid-frame, then back-to-back.**
  - Assert `rst_n`=0 after 10 beats of a 4×4 ramp: all outputs 0 and no pulses.
  - Release, then send two consecutive 4×4 ramps with no gap: outputs 5, 7, 13, 15 twice, with two `frame_done` pulses 16 cycles apart.

Source files
------------

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by a 2x2 / stride-2 max-pool over a raster-ordered feature map.
// Holds only one half-width row of pair maxima in a line buffer; no frame storage.
module relu_maxpool2x2 #(
    parameter int IW = 26,
    parameter int IH = 26,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          frame_done
);

    localparam int OW = IW / 2;
    localparam int OH = IH / 2;
    localparam int CW = $clog2(IW + 1);
    localparam int RW = $clog2(IH + 1);
    localparam int AW = (OW > 1) ? $clog2(OW) : 1;

    localparam logic [CW-1:0] C_LAST  = CW'(IW - 1);
    localparam logic [RW-1:0] R_LAST  = RW'(IH - 1);
    localparam logic [CW-1:0] C_PLAST = CW'(2 * OW - 1);
    localparam logic [RW-1:0] R_PLAST = RW'(2 * OH - 1);
    localparam bit            IW_ODD  = (IW % 2) != 0;
    localparam bit            IH_ODD  = (IH % 2) != 0;

    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    logic [DW-1:0] h_q, h_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          frame_done_q, frame_done_d;

    logic [DW-1:0] lb_mem [0:OW-1];
    logic [DW-1:0] lb_rd_q;

    logic [DW-1:0] x_relu;
    logic [DW-1:0] m_pair;
    logic [DW-1:0] pool_max;
    logic          col_kept;
    logic          row_kept;
    logic          pair_done;
    logic          lb_wr_en;
    logic          lb_rd_en;
    logic [AW-1:0] lb_idx;

    // Datapath: after ReLU every value is non-negative, so unsigned compares suffice.
    always_comb begin
        x_relu    = in_data[DW-1] ? '0 : in_data;
        m_pair    = (x_relu > h_q) ? x_relu : h_q;
        pool_max  = (m_pair > lb_rd_q) ? m_pair : lb_rd_q;
        col_kept  = !(IW_ODD && (c_q == C_LAST));
        row_kept  = !(IH_ODD && (r_q == R_LAST));
        pair_done = in_valid && c_q[0];
        lb_idx    = AW'(c_q >> 1);
        lb_wr_en  = pair_done && !r_q[0] && row_kept;
        // Prefetch the upper-row maximum on the even column so the read is registered.
        lb_rd_en  = in_valid && !c_q[0] && col_kept && r_q[0];
    end

    always_comb begin
        c_d          = c_q;
        r_d          = r_q;
        h_d          = h_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_last_d   = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            if (!c_q[0] && col_kept) begin
                h_d = x_relu;
            end
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
            frame_done_d = (c_q == C_LAST) && (r_q == R_LAST);
        end
        if (pair_done && r_q[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = pool_max;
            out_last_d  = (r_q == R_PLAST) && (c_q == C_PLAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q          <= '0;
            r_q          <= '0;
            h_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            c_q          <= c_d;
            r_q          <= r_d;
            h_q          <= h_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer contents need no reset: each entry is rewritten on an even row before use.
    always_ff @(posedge clk) begin
        if (lb_wr_en) begin
            lb_mem[lb_idx] <= m_pair;
        end
        if (lb_rd_en) begin
            lb_rd_q <= lb_mem[lb_idx];
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Scoreboard bench for relu_maxpool2x2: four instances (4x4, 26x26, 5x5, 2x2) share clock and reset.
module tb_relu_maxpool2x2;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        f;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  iv = '0;
    logic [15:0] idat [4];
    logic [3:0]  ov, ol, fd;
    logic [15:0] od [4];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relu_maxpool2x2 #(.IW(4), .IH(4), .DW(16)) u_4x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .frame_done(fd[0]));
    relu_maxpool2x2 #(.IW(26), .IH(26), .DW(16)) u_26x26 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .frame_done(fd[1]));
    relu_maxpool2x2 #(.IW(5), .IH(5), .DW(16)) u_5x5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(idat[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]), .frame_done(fd[2]));
    relu_maxpool2x2 #(.IW(2), .IH(2), .DW(16)) u_2x2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_data(idat[3]),
        .out_valid(ov[3]), .out_data(od[3]), .out_last(ol[3]), .frame_done(fd[3]));

    function automatic int qsize(input int s);
        case (s)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic qpush(input int s, input exp_t e);
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic qpop(input int s, output exp_t e);
        case (s)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    function automatic int qfront_cyc(input int s);
        case (s)
            0: return q0[0].cyc;
            1: return q1[0].cyc;
            2: return q2[0].cyc;
            default: return q3[0].cyc;
        endcase
    endfunction

    task automatic cmp(input string name, input int s, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, required %0d", name, s, cyc, act, req);
        end
    endtask

    // Monitor: every output event (out_valid or frame_done) must match the queue head.
    task automatic monitor(input int s);
        exp_t e;
        while (qsize(s) > 0 && qfront_cyc(s) < cyc) begin
            qpop(s, e);
            checks++;
            errors++;
            $display("FAIL missing_event dut%0d: expected at cycle %0d data=%0d, got nothing by cycle %0d",
                     s, e.cyc, e.d, cyc);
        end
        if (!(ov[s] || fd[s])) return;
        if (qsize(s) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event dut%0d cycle %0d: valid=%0b data=%0d last=%0b fd=%0b, required no event",
                     s, cyc, ov[s], od[s], ol[s], fd[s]);
            return;
        end
        qpop(s, e);
        cmp("event_cycle", s, cyc, e.cyc);
        cmp("out_valid", s, int'(ov[s]), int'(e.v));
        if (e.v) cmp("out_data", s, int'(od[s]), int'(e.d));
        cmp("out_last", s, int'(ol[s]), int'(e.l));
        cmp("frame_done", s, int'(fd[s]), int'(e.f));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 4; s++) monitor(s);
        end
    end

    // Drive one cycle on instance s; optionally register the event it must cause one cycle later.
    task automatic step(input int s, input logic v, input logic [15:0] d,
                        input logic ev, input logic evv, input logic [15:0] ed,
                        input logic el, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        iv      = '0;
        iv[s]   = v;
        idat[s] = d;
        if (ev) begin
            e.v   = evv;
            e.d   = ed;
            e.l   = el;
            e.f   = ef;
            e.cyc = cyc + 1;
            qpush(s, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic check_quiet(input int s, input string tag);
        @(negedge clk);
        cmp({tag, "_valid"}, s, int'(ov[s]), 0);
        cmp({tag, "_data"}, s, int'(od[s]), 0);
        cmp({tag, "_last"}, s, int'(ol[s]), 0);
        cmp({tag, "_fdone"}, s, int'(fd[s]), 0);
    endtask

    // 4x4 ramp 0..15: outputs at beats 5,7,13,15 with those values; last and frame_done on 15.
    function automatic int ramp4_hit(input int k);
        int idx [4];
        idx = '{5, 7, 13, 15};
        for (int i = 0; i < 4; i++) if (idx[i] == k) return 1;
        return 0;
    endfunction

    task automatic ramp4(input int gap);
        for (int k = 0; k < 16; k++) begin
            step(0, 1'b1, 16'(k), 1'(ramp4_hit(k)), 1'b1, 16'(k), k == 15, k == 15);
            if (gap != 0) idle(1);
        end
    endtask

    initial begin
        int idx5 [4];
        int val5 [4];
        logic [15:0] v2 [4];
        for (int s = 0; s < 4; s++) idat[s] = '0;

        repeat (3) @(posedge clk);
        for (int s = 0; s < 4; s++) check_quiet(s, "reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        ramp4(0);
        idle(3);

        for (int k = 0; k < 676; k++) begin
            step(1, 1'b1, 16'hFFFF, ((k / 26) % 2 == 1) && ((k % 26) % 2 == 1),
                 1'b1, 16'd0, k == 675, k == 675);
        end
        idle(3);

        ramp4(1);
        idle(3);

        // 5x5 ramp: pooled 6,8,16,18 from beats 6,8,16,18; frame_done alone after beat 24.
        idx5 = '{6, 8, 16, 18};
        val5 = '{6, 8, 16, 18};
        for (int k = 0; k < 25; k++) begin
            logic hit;
            logic [15:0] hv;
            hit = 1'b0;
            hv  = 16'd0;
            for (int i = 0; i < 4; i++) if (idx5[i] == k) begin hit = 1'b1; hv = 16'(val5[i]); end
            if (k == 24) step(2, 1'b1, 16'(k), 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
            else         step(2, 1'b1, 16'(k), hit, 1'b1, hv, k == 18, 1'b0);
        end
        idle(3);

        v2 = '{16'hFED4, 16'h0007, 16'hFFFF, 16'h7FFF};
        for (int k = 0; k < 4; k++) begin
            step(3, 1'b1, v2[k], k == 3, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        end
        idle(3);

        // Abort a 4x4 frame after 10 beats; beats 5 and 7 have already produced outputs.
        for (int k = 0; k < 10; k++) begin
            step(0, 1'b1, 16'(k), k == 5 || k == 7, 1'b1, 16'(k), 1'b0, 1'b0);
        end
        idle(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        check_quiet(0, "midreset");
        check_quiet(0, "midreset_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        ramp4(0);
        ramp4(0);
        idle(5);

        for (int s = 0; s < 4; s++) cmp("queue_drained", s, qsize(s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
